// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types and constants for the OTTER memory port arbiter.
package otter_mem_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      PLOCK = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      PROG = 2'd1,
      DMEM = 2'd2,
      IMEM = 2'd3
   } req_id_t;

   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   // Bit positions inside the one-hot grant vector.
   localparam int GNT_PROG = 0;
   localparam int GNT_DMEM = 1;
   localparam int GNT_IMEM = 2;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Request/response and memory-command bundle around the OTTER port arbiter.
// master = requesters plus memory (the environment), slave = the arbiter.
interface otter_mem_arbiter_if #(parameter int ADDR_W = 32);

   logic              PROG_REQ, DMEM_REQ, IMEM_REQ;
   logic              PROG_WE, DMEM_WE;
   logic [ADDR_W-1:0] PROG_ADDR, DMEM_ADDR, IMEM_ADDR;
   logic [31:0]       PROG_WDATA, DMEM_WDATA;
   logic [1:0]        DMEM_SIZE;
   logic              DMEM_SIGN;

   logic              PROG_GNT, DMEM_GNT, IMEM_GNT;
   logic              DMEM_RVALID, IMEM_RVALID;
   logic [31:0]       RDATA;
   logic              DMEM_STALL, IMEM_STALL;
   logic              CORE_LOCK;

   logic              MEM_EN, MEM_WE;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [31:0]       MEM_DIN;
   logic [1:0]        MEM_SIZE;
   logic              MEM_SIGN;
   logic [31:0]       MEM_DOUT;

   modport master (
      output PROG_REQ, DMEM_REQ, IMEM_REQ, PROG_WE, DMEM_WE,
      output PROG_ADDR, DMEM_ADDR, IMEM_ADDR, PROG_WDATA, DMEM_WDATA,
      output DMEM_SIZE, DMEM_SIGN, MEM_DOUT,
      input  PROG_GNT, DMEM_GNT, IMEM_GNT, DMEM_RVALID, IMEM_RVALID, RDATA,
      input  DMEM_STALL, IMEM_STALL, CORE_LOCK,
      input  MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN, MEM_SIZE, MEM_SIGN
   );

   modport slave (
      input  PROG_REQ, DMEM_REQ, IMEM_REQ, PROG_WE, DMEM_WE,
      input  PROG_ADDR, DMEM_ADDR, IMEM_ADDR, PROG_WDATA, DMEM_WDATA,
      input  DMEM_SIZE, DMEM_SIGN, MEM_DOUT,
      output PROG_GNT, DMEM_GNT, IMEM_GNT, DMEM_RVALID, IMEM_RVALID, RDATA,
      output DMEM_STALL, IMEM_STALL, CORE_LOCK,
      output MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN, MEM_SIZE, MEM_SIGN
   );

endinterface

// File: rtl/otter_mem_arbiter_prio.sv
// Three-way fixed-priority picker; promote_imem lifts IMEM above DMEM.
module otter_arb_prio
   import otter_mem_pkg::*;
(
   input  logic       prog_req,
   input  logic       dmem_req,
   input  logic       imem_req,
   input  logic       promote_imem,
   output logic [2:0] gnt
);

   // One-hot pick: PROG always first, IMEM jumps DMEM only when promoted.
   always_comb begin
      gnt = '0;
      if (prog_req)
         gnt[GNT_PROG] = 1'b1;
      else if (promote_imem && imem_req)
         gnt[GNT_IMEM] = 1'b1;
      else if (dmem_req)
         gnt[GNT_DMEM] = 1'b1;
      else if (imem_req)
         gnt[GNT_IMEM] = 1'b1;
   end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares OTTER_mem_byte port 2 between programmer, MEM-stage and fetch.
// Grants are combinational, read responses return one cycle later tagged
// to their owner, and programmer traffic locks the core off the port.
module otter_mem_arbiter
   import otter_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int STARVE_LIM = 4,
   parameter int HOLD_CYC   = 16
)(
   input  logic CLK,
   input  logic RESET_N,
   otter_mem_arbiter_if.slave bus
);

   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYC);

   logic              ready;
   arb_state_t        state;
   logic [SW-1:0]     starve_cnt;
   logic [HW-1:0]     hold_cnt;
   req_id_t           resp_tag;

   logic [2:0]        gnt;
   logic              prog_gnt, dmem_gnt, imem_gnt;
   logic              promote;

   logic              mem_en_mux, mem_we_mux, mem_sign_mux;
   logic [ADDR_W-1:0] mem_addr_mux;
   logic [31:0]       mem_din_mux;
   logic [1:0]        mem_size_mux;

   assign promote = (starve_cnt == STARVE_MAX);

   otter_arb_prio u_prio (
      .prog_req     (ready & bus.PROG_REQ),
      .dmem_req     (ready & (state == RUN) & bus.DMEM_REQ),
      .imem_req     (ready & (state == RUN) & bus.IMEM_REQ),
      .promote_imem (promote),
      .gnt          (gnt)
   );

   assign prog_gnt = gnt[GNT_PROG];
   assign dmem_gnt = gnt[GNT_DMEM];
   assign imem_gnt = gnt[GNT_IMEM];

   // Route the granted requester's command onto the memory port.
   always_comb begin
      mem_en_mux   = 1'b0;
      mem_we_mux   = 1'b0;
      mem_addr_mux = '0;
      mem_din_mux  = '0;
      mem_size_mux = '0;
      mem_sign_mux = 1'b0;
      if (prog_gnt) begin
         mem_en_mux   = 1'b1;
         mem_we_mux   = bus.PROG_WE;
         mem_addr_mux = bus.PROG_ADDR;
         mem_din_mux  = bus.PROG_WDATA;
         mem_size_mux = MEM_SIZE_WORD;
      end else if (dmem_gnt) begin
         mem_en_mux   = 1'b1;
         mem_we_mux   = bus.DMEM_WE;
         mem_addr_mux = bus.DMEM_ADDR;
         mem_din_mux  = bus.DMEM_WDATA;
         mem_size_mux = bus.DMEM_SIZE;
         mem_sign_mux = bus.DMEM_SIGN;
      end else if (imem_gnt) begin
         mem_en_mux   = 1'b1;
         mem_addr_mux = bus.IMEM_ADDR;
         mem_size_mux = MEM_SIZE_WORD;
      end
   end

   // Outputs stay quiet until the first clock after reset release.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) ready <= 1'b0;
      else          ready <= 1'b1;
   end

   // Programmer lock: enter on a PROG grant, stay while PROG keeps asking,
   // and leave in the cycle the hold counter runs down to zero.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= RUN;
         hold_cnt <= '0;
      end else if (ready) begin
         case (state)
            RUN: begin
               if (prog_gnt) begin
                  state    <= PLOCK;
                  hold_cnt <= HOLD_MAX;
               end
            end
            PLOCK: begin
               if (bus.PROG_REQ) begin
                  hold_cnt <= HOLD_MAX;
               end else if (hold_cnt <= HW'(1)) begin
                  hold_cnt <= '0;
                  state    <= RUN;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // Count consecutive denied fetch cycles so IMEM cannot starve behind DMEM.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         starve_cnt <= '0;
      end else if (ready && state == RUN) begin
         if (!bus.IMEM_REQ || imem_gnt)
            starve_cnt <= '0;
         else if (!promote)
            starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // Remember who owns the read issued this cycle so its data returns to it.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)                    resp_tag <= NONE;
      else if (prog_gnt && !bus.PROG_WE) resp_tag <= PROG;
      else if (dmem_gnt && !bus.DMEM_WE) resp_tag <= DMEM;
      else if (imem_gnt)               resp_tag <= IMEM;
      else                             resp_tag <= NONE;
   end

   assign bus.PROG_GNT    = prog_gnt;
   assign bus.DMEM_GNT    = dmem_gnt;
   assign bus.IMEM_GNT    = imem_gnt;
   assign bus.DMEM_STALL  = ready & bus.DMEM_REQ & ~dmem_gnt;
   assign bus.IMEM_STALL  = ready & bus.IMEM_REQ & ~imem_gnt;
   assign bus.CORE_LOCK   = ready & ((state == PLOCK) | prog_gnt);
   assign bus.DMEM_RVALID = ready & (resp_tag == DMEM);
   assign bus.IMEM_RVALID = ready & (resp_tag == IMEM);
   assign bus.RDATA       = (ready && resp_tag != NONE) ? bus.MEM_DOUT : 32'h0;

   assign bus.MEM_EN   = mem_en_mux;
   assign bus.MEM_WE   = mem_we_mux;
   assign bus.MEM_ADDR = mem_addr_mux;
   assign bus.MEM_DIN  = mem_din_mux;
   assign bus.MEM_SIZE = mem_size_mux;
   assign bus.MEM_SIGN = mem_sign_mux;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: grants, starvation promotion,
// pipelined reads, programmer lock with hold/reload, and reset behaviour.
module tb_otter_mem_arbiter;

   logic clk;
   logic rst_n;
   int   assertCount;
   int   failCount;

   otter_mem_arbiter_if #(.ADDR_W(32)) bus ();

   otter_mem_arbiter #(
      .ADDR_W     (32),
      .STARVE_LIM (4),
      .HOLD_CYC   (16)
   ) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Every output must be zero while the arbiter is not ready.
   task automatic checkAllZero(input string tag);
      logic [31:0] ctrl;
      ctrl = {19'b0, bus.PROG_GNT, bus.DMEM_GNT, bus.IMEM_GNT, bus.DMEM_RVALID,
              bus.IMEM_RVALID, bus.DMEM_STALL, bus.IMEM_STALL, bus.CORE_LOCK,
              bus.MEM_EN, bus.MEM_WE, bus.MEM_SIZE, bus.MEM_SIGN};
      checkOutput({tag, "_ctrl"}, ctrl, 32'h0);
      checkOutput({tag, "_addr"}, bus.MEM_ADDR, 32'h0);
      checkOutput({tag, "_din"}, bus.MEM_DIN, 32'h0);
      checkOutput({tag, "_rdata"}, bus.RDATA, 32'h0);
   endtask

   // Drive one cycle of inputs at the falling edge, settle, then let checks run.
   task automatic applyStimulus(
      input logic preq, input logic pwe, input logic [31:0] paddr, input logic [31:0] pwdata,
      input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
      input logic [1:0] dsize, input logic dsign,
      input logic ireq, input logic [31:0] iaddr, input logic [31:0] dout);
      @(negedge clk);
      bus.PROG_REQ   = preq;
      bus.PROG_WE    = pwe;
      bus.PROG_ADDR  = paddr;
      bus.PROG_WDATA = pwdata;
      bus.DMEM_REQ   = dreq;
      bus.DMEM_WE    = dwe;
      bus.DMEM_ADDR  = daddr;
      bus.DMEM_WDATA = dwdata;
      bus.DMEM_SIZE  = dsize;
      bus.DMEM_SIGN  = dsign;
      bus.IMEM_REQ   = ireq;
      bus.IMEM_ADDR  = iaddr;
      bus.MEM_DOUT   = dout;
      #2;
   endtask

   task automatic idleCycle(input logic [31:0] dout);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, dout);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst_n       = 1'b0;

      // Reset with every requester active: outputs must stay zero.
      applyStimulus(1, 1, 32'h40, 32'h1111, 1, 0, 32'h80, 32'h2222, 2'b01, 1, 1, 32'h90, 32'hFFFFFFFF);
      checkAllZero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      checkAllZero("prerdy");

      // Test 1: single fetch and its response one cycle later.
      $display("[TB] test 1: IMEM fetch");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 32'h100, 32'h0);
      checkOutput("t1_ignt", bus.IMEM_GNT, 1);
      checkOutput("t1_en", bus.MEM_EN, 1);
      checkOutput("t1_addr", bus.MEM_ADDR, 32'h100);
      checkOutput("t1_we", bus.MEM_WE, 0);
      checkOutput("t1_size", bus.MEM_SIZE, 2'b10);
      checkOutput("t1_lock", bus.CORE_LOCK, 0);
      idleCycle(32'hDEADBEEF);
      checkOutput("t1_irv", bus.IMEM_RVALID, 1);
      checkOutput("t1_drv", bus.DMEM_RVALID, 0);
      checkOutput("t1_rdata", bus.RDATA, 32'hDEADBEEF);
      checkOutput("t1_idle_en", bus.MEM_EN, 0);
      idleCycle(32'h12121212);
      checkOutput("t1_irv_off", bus.IMEM_RVALID, 0);
      checkOutput("t1_rdata_off", bus.RDATA, 32'h0);

      // Test 2: DMEM vs IMEM contention, IMEM promoted on the fifth cycle.
      $display("[TB] test 2: starvation promotion");
      for (int c = 0; c < 6; c++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 32'h2000, 0, 2'b10, 0, 1, 32'h104, 32'hA0000000 + c);
         checkOutput("t2_dgnt", bus.DMEM_GNT, (c != 4));
         checkOutput("t2_ignt", bus.IMEM_GNT, (c == 4));
         checkOutput("t2_istall", bus.IMEM_STALL, (c != 4));
         checkOutput("t2_dstall", bus.DMEM_STALL, (c == 4));
         checkOutput("t2_addr", bus.MEM_ADDR, (c == 4) ? 32'h104 : 32'h2000);
         if (c > 0) begin
            checkOutput("t2_drv", bus.DMEM_RVALID, (c != 5));
            checkOutput("t2_irv", bus.IMEM_RVALID, (c == 5));
            checkOutput("t2_rdata", bus.RDATA, 32'hA0000000 + c);
         end
      end
      idleCycle(32'h0);
      idleCycle(32'h0);

      // Test 3: back-to-back DMEM reads, then a signed byte store.
      $display("[TB] test 3: pipelined DMEM reads and a store");
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 0, 2'b10, 0, 0, 0, 32'h0);
      checkOutput("t3_gnt0", bus.DMEM_GNT, 1);
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h14, 0, 2'b10, 0, 0, 0, 32'h11111111);
      checkOutput("t3_rv1", bus.DMEM_RVALID, 1);
      checkOutput("t3_rd1", bus.RDATA, 32'h11111111);
      checkOutput("t3_addr1", bus.MEM_ADDR, 32'h14);
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h18, 0, 2'b10, 0, 0, 0, 32'h22222222);
      checkOutput("t3_rv2", bus.DMEM_RVALID, 1);
      checkOutput("t3_rd2", bus.RDATA, 32'h22222222);
      checkOutput("t3_irv2", bus.IMEM_RVALID, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'hCAFEF00D, 2'b00, 1, 0, 0, 32'h33333333);
      checkOutput("t3_rv3", bus.DMEM_RVALID, 1);
      checkOutput("t3_rd3", bus.RDATA, 32'h33333333);
      checkOutput("t3_st_we", bus.MEM_WE, 1);
      checkOutput("t3_st_din", bus.MEM_DIN, 32'hCAFEF00D);
      checkOutput("t3_st_size", bus.MEM_SIZE, 2'b00);
      checkOutput("t3_st_sign", bus.MEM_SIGN, 1);
      idleCycle(32'h44444444);
      checkOutput("t3_st_norv", bus.DMEM_RVALID, 0);
      checkOutput("t3_st_nodata", bus.RDATA, 32'h0);

      // Test 4: programmer write takes the port and locks the core.
      $display("[TB] test 4: programmer lock");
      applyStimulus(1, 1, 32'h0, 32'h12345678, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 32'h0);
      checkOutput("t4_pgnt", bus.PROG_GNT, 1);
      checkOutput("t4_dgnt", bus.DMEM_GNT, 0);
      checkOutput("t4_dstall", bus.DMEM_STALL, 1);
      checkOutput("t4_we", bus.MEM_WE, 1);
      checkOutput("t4_size", bus.MEM_SIZE, 2'b10);
      checkOutput("t4_din", bus.MEM_DIN, 32'h12345678);
      checkOutput("t4_lock", bus.CORE_LOCK, 1);
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 32'h0);
         checkOutput("t4_hold_lock", bus.CORE_LOCK, 1);
         checkOutput("t4_hold_dgnt", bus.DMEM_GNT, 0);
         checkOutput("t4_hold_en", bus.MEM_EN, 0);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 32'h0);
      checkOutput("t4_c17_dgnt", bus.DMEM_GNT, 1);
      checkOutput("t4_c17_lock", bus.CORE_LOCK, 0);
      idleCycle(32'h0);

      // Test 4b: PROG_REQ on the last hold cycle reloads the lock.
      $display("[TB] test 4b: lock reload on final hold cycle");
      applyStimulus(1, 1, 32'h0, 32'hAAAA0000, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 32'h0);
      for (int k = 1; k <= 15; k++)
         applyStimulus(0, 0, 0, 0, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 32'h0);
      applyStimulus(1, 1, 32'h4, 32'hBBBB0000, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 32'h0);
      checkOutput("t4b_pgnt", bus.PROG_GNT, 1);
      checkOutput("t4b_addr", bus.MEM_ADDR, 32'h4);
      for (int k = 17; k <= 32; k++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 32'h0);
         checkOutput("t4b_lock", bus.CORE_LOCK, 1);
         checkOutput("t4b_dgnt", bus.DMEM_GNT, 0);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h2000, 0, 2'b10, 0, 0, 0, 32'h0);
      checkOutput("t4b_c33_dgnt", bus.DMEM_GNT, 1);
      checkOutput("t4b_c33_lock", bus.CORE_LOCK, 0);
      idleCycle(32'h0);

      // Test 5: fetch in flight when the programmer arrives still returns.
      $display("[TB] test 5: outstanding fetch across lock entry");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 32'h200, 32'h0);
      checkOutput("t5_ignt", bus.IMEM_GNT, 1);
      applyStimulus(1, 0, 32'h8, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h55AA55AA);
      checkOutput("t5_irv", bus.IMEM_RVALID, 1);
      checkOutput("t5_rdata", bus.RDATA, 32'h55AA55AA);
      checkOutput("t5_lock", bus.CORE_LOCK, 1);
      checkOutput("t5_pgnt", bus.PROG_GNT, 1);
      idleCycle(32'h0F0F0F0F);
      checkOutput("t5_prd", bus.RDATA, 32'h0F0F0F0F);
      checkOutput("t5_irv_off", bus.IMEM_RVALID, 0);
      checkOutput("t5_drv_off", bus.DMEM_RVALID, 0);
      for (int k = 3; k <= 17; k++) idleCycle(32'h0);
      checkOutput("t5_c17_lock", bus.CORE_LOCK, 1);
      idleCycle(32'h0);
      checkOutput("t5_c18_lock", bus.CORE_LOCK, 0);

      // Test 6: reset during an outstanding read drops it and clears counters.
      $display("[TB] test 6: reset mid-read");
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 32'h40, 0, 2'b10, 0, 1, 32'h300, 32'h0);
         checkOutput("t6_pre_dgnt", bus.DMEM_GNT, 1);
      end
      @(negedge clk);
      rst_n = 1'b0;
      bus.MEM_DOUT = 32'h77777777;
      #2;
      checkAllZero("t6_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      checkAllZero("t6_prerdy");
      for (int c = 0; c < 5; c++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 32'h40, 0, 2'b10, 0, 1, 32'h300, 32'h0);
         checkOutput("t6_dgnt", bus.DMEM_GNT, (c != 4));
         checkOutput("t6_ignt", bus.IMEM_GNT, (c == 4));
         checkOutput("t6_lock", bus.CORE_LOCK, 0);
         if (c == 0) checkOutput("t6_norv", bus.DMEM_RVALID, 0);
      end
      idleCycle(32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares the single data-capable memory port among three requesters: serial programmer (PROG), MEM-stage load/store (DMEM) and instruction fetch (IMEM).
- Sits between the pipelined OTTER core and OTTER_mem_byte port 2, and replaces the ad-hoc programmer 2:1 muxes.
- Issues at most one command per cycle, tags outstanding reads and routes read data back to the owner.
- Drives per-requester stall outputs, and holds the core off the port during programmer bursts.

Parameters:
- ADDR_W, 32, address width
- STARVE_LIM, 4, consecutive denied IMEM request cycles before IMEM outranks DMEM for one grant
- HOLD_CYC, 16, cycles the programmer lock persists after the last PROG_REQ

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- PROG_REQ, DMEM_REQ, IMEM_REQ  in  1 each  request valid, held until granted
- PROG_WE, DMEM_WE  in  1 each  write enable (IMEM is read-only)
- PROG_ADDR, DMEM_ADDR, IMEM_ADDR  in  ADDR_W each  byte address
- PROG_WDATA, DMEM_WDATA  in  32 each  write data
- DMEM_SIZE  in  2  size (PROG is fixed at word 2'b10; IMEM is fixed at word, unsigned)
- DMEM_SIGN  in  1  sign
- PROG_GNT, DMEM_GNT, IMEM_GNT  out  1 each  request accepted this cycle
- DMEM_RVALID, IMEM_RVALID  out  1 each  RDATA valid for that requester
- RDATA  out  32  read data, shared
- DMEM_STALL, IMEM_STALL  out  1 each  REQ & ~GNT
- CORE_LOCK  out  1  programmer owns the port; the pipeline must freeze
- MEM_EN, MEM_WE  out  1 each  memory command
- MEM_ADDR  out  ADDR_W  memory address
- MEM_DIN  out  32  memory write data
- MEM_SIZE  out  2  memory size
- MEM_SIGN  out  1  memory sign
- MEM_DOUT  in  32  memory read data, valid 1 cycle after MEM_EN & ~MEM_WE

Behaviour:
- Reset (RESET_N=0, asynchronous) clears:
  - state to RUN, starve_cnt to 0, hold_cnt to 0;
  - resp_tag to NONE and the ready flop to 0.
- While ready=0, every output is 0: all GNT, RVALID and STALL, CORE_LOCK, all MEM_* buses, and RDATA.
- ready sets on the first CLK edge after RESET_N rises.
- Grant is combinational in the request cycle; the MEM_* command is a combinational mux of the granted requester.
- Read response appears exactly 1 cycle after the grant: RVALID=1 for the tagged owner, RDATA=MEM_DOUT. Writes produce no response.
- resp_tag (NONE/DMEM/IMEM) is registered each cycle from the grant. Back-to-back reads are fully pipelined, one per cycle.
- FSM:
  - RUN: priority is PROG > DMEM > IMEM. When IMEM is promoted (starve_cnt==STARVE_LIM), the order becomes PROG > IMEM > DMEM for that cycle only. PROG_REQ=1 grants PROG, moves to PLOCK, and loads hold_cnt=HOLD_CYC.
  - PLOCK: CORE_LOCK=1. Only PROG may be granted; DMEM and IMEM stall. PROG_REQ=1 reloads hold_cnt=HOLD_CYC; otherwise hold_cnt decrements. hold_cnt==0 with PROG_REQ=0 returns to RUN next cycle.
  - Tie rule: a PROG_REQ in the same cycle as the hold_cnt==0 transition wins, so the FSM stays in PLOCK and reloads.
- starve_cnt:
  - increments while IMEM_REQ & ~IMEM_GNT in RUN, saturating at STARVE_LIM;
  - clears on IMEM_GNT, or when IMEM_REQ=0;
  - freezes in PLOCK.
- A read outstanding on entry to PLOCK still returns its RVALID; the tag is unaffected by the state change.
- Asynchronous reset mid-read drops the response: no RVALID after reset.
- Simultaneous DMEM and IMEM requests with starve_cnt<STARVE_LIM: DMEM wins, IMEM_STALL=1.
- No request in a cycle: MEM_EN=0 and resp_tag goes to NONE.
- The arbiter does not reorder, buffer or retry; each requester must hold its request stable until granted.

Decomposition:
- Shared package otter_mem_pkg holds:
  - enum arb_state_t {RUN, PLOCK};
  - enum req_id_t {NONE, PROG, DMEM, IMEM};
  - localparam MEM_SIZE_WORD=2'b10.
- One sub-module, otter_arb_prio: a combinational 3-way priority picker with a promote_imem input. It returns a one-hot grant and is reused by the FSM.

Test Plan:
1. Reset, then IMEM_REQ=1 at 0x100 with MEM_DOUT=0xDEADBEEF the next cycle -> IMEM_GNT=1 in cycle 0; IMEM_RVALID=1, RDATA=0xDEADBEEF in cycle 1; all outputs 0 during reset.
2. DMEM load at 0x2000 and IMEM at 0x104 every cycle -> DMEM granted in cycles 0-3 with IMEM_STALL=1; IMEM granted in cycle 4 (starve_cnt=4), DMEM_STALL=1 that cycle; starve_cnt=0 after.
3. Back-to-back DMEM reads 0x10, 0x14, 0x18 -> three consecutive DMEM_RVALID pulses one cycle late, data order preserved, no IMEM_RVALID.
4. PROG_REQ write 0x0/0x12345678 while DMEM requests -> PROG granted, MEM_WE=1, MEM_SIZE=2'b10, CORE_LOCK=1. Lock held 16 cycles after the last PROG_REQ, then DMEM granted in cycle 17.
5. IMEM read granted, then PROG_REQ in the next cycle -> IMEM_RVALID still asserted in that cycle, and CORE_LOCK rises.
6. RESET_N pulled low the cycle after a DMEM read grant -> no DMEM_RVALID; state RUN and counters 0 after release.
